// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- program-counter generator for the front of the core.
//
// Holds the current fetch PC and selects the next one with priority
// trap > redirect > hold (halt / stall / fetch not ready) > sequential step.
// A BOOT -> RUN <-> HALT state machine drives the system enable and the
// fetch valid/ready handshake. Accepted fetches (valid & ready) are counted.
//
// Optional feature (compile-time macro PC_ALIGN_CHK_EN):
//   defined   : redirects to a target not aligned to PC_STEP are rejected
//               and misalign_o pulses for one cycle.
//   undefined : redirects are taken as-is; misalign_o is tied to 0.
//
// Parameters:
//   PC_WIDTH     PC and target width in bits
//   RESET_PC     PC loaded at reset and held during BOOT
//   PC_STEP      sequential increment (power of two, >= 1)
//   BOOT_CYCLES  clocks spent in BOOT after reset release (>= 1)
//   CNT_WIDTH    width of the accepted-fetch counter
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena_o               system enable, 1 only in RUN
//   stall_i             downstream stall, hold PC
//   halt_i / resume_i   enter / leave HALT
//   redirect_i/_pc_i    branch/jump taken and its target
//   trap_i / trap_pc_i  trap entry and its vector
//   fetch_valid_o       pc_o is a valid fetch request
//   fetch_ready_i       fetch stage accepts pc_o
//   pc_o                current PC
//   fetch_cnt_o         number of accepted fetches (wraps)
//   misalign_o          one-cycle pulse on a rejected misaligned redirect
// ---------------------------------------------------------------------------
module pc_gen #(
  parameter int unsigned            PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter int unsigned            PC_STEP     = 4,
  parameter int unsigned            BOOT_CYCLES = 1,
  parameter int unsigned            CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ena_o,
  input  logic                 stall_i,
  input  logic                 halt_i,
  input  logic                 resume_i,
  input  logic                 redirect_i,
  input  logic [PC_WIDTH-1:0]  redirect_pc_i,
  input  logic                 trap_i,
  input  logic [PC_WIDTH-1:0]  trap_pc_i,
  output logic                 fetch_valid_o,
  input  logic                 fetch_ready_i,
  output logic [PC_WIDTH-1:0]  pc_o,
  output logic [CNT_WIDTH-1:0] fetch_cnt_o,
  output logic                 misalign_o
);

  // State encoding kept as plain constants for compatibility with existing
  // tooling that decodes the state register.
  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  // The boot counter only ever needs to reach BOOT_CYCLES-1.
  localparam int unsigned          BOOT_CW   = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_CW-1:0]   BOOT_LAST = BOOT_CW'(BOOT_CYCLES - 1);
  localparam logic [PC_WIDTH-1:0]  PC_INC    = PC_WIDTH'(PC_STEP);

  logic [1:0]           state_q,    state_d;
  logic [BOOT_CW-1:0]   boot_cnt_q, boot_cnt_d;
  logic [PC_WIDTH-1:0]  pc_q,       pc_d;
  logic [CNT_WIDTH-1:0] cnt_q,      cnt_d;
  logic                 run_q,      run_d;

  logic redir_misaligned;
  logic redirect_ok;

  // -------------------------------------------------------------------------
  // Redirect alignment check
  // -------------------------------------------------------------------------
`ifdef PC_ALIGN_CHK_EN
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(PC_STEP - 1);

  logic misalign_q, misalign_d;

  assign redir_misaligned = |(redirect_pc_i & ALIGN_MASK);

  // Only a redirect that would actually have been taken counts as rejected:
  // in RUN and not overridden by a trap in the same cycle.
  assign misalign_d = (state_q == ST_RUN) & redirect_i & ~trap_i & redir_misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end

  assign misalign_o = misalign_q;
`else
  assign redir_misaligned = 1'b0;
  assign misalign_o       = 1'b0;
`endif

  // A rejected redirect behaves exactly as if redirect_i were low.
  assign redirect_ok = redirect_i & ~redir_misaligned;

  // -------------------------------------------------------------------------
  // Next-state / next-PC logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it
    // unassigned -- otherwise a latch is inferred.
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_BOOT: begin
        // All requests are ignored while booting.
        pc_d       = RESET_PC;
        boot_cnt_d = boot_cnt_q + BOOT_CW'(1);
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = ST_RUN;
          boot_cnt_d = '0;
        end
      end

      ST_RUN: begin
        // fetch_valid_o is 1 throughout RUN, so ready alone means accepted.
        if (fetch_ready_i) cnt_d = cnt_q + CNT_WIDTH'(1);

        if (trap_i)                                pc_d = trap_pc_i;
        else if (redirect_ok)                      pc_d = redirect_pc_i;
        else if (halt_i || stall_i || !fetch_ready_i) pc_d = pc_q;
        else                                       pc_d = pc_q + PC_INC;

        // A trap keeps the core running; a redirect does not block halting.
        if (halt_i && !trap_i) state_d = ST_HALT;
      end

      ST_HALT: begin
        // redirect/stall/halt are ignored; trap wakes up with a new PC,
        // resume wakes up with the PC unchanged.
        if (trap_i) begin
          pc_d    = trap_pc_i;
          state_d = ST_RUN;
        end else if (resume_i) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d    = ST_BOOT;
        boot_cnt_d = '0;
        pc_d       = RESET_PC;
      end
    endcase

    // Enable and valid are registered decodes of the upcoming state so they
    // change on the same edge as the state itself.
    run_d = (state_d == ST_RUN);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // their inputs before any of them update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
    end
  end

  assign ena_o         = run_q;
  assign fetch_valid_o = run_q;
  assign pc_o          = pc_q;
  assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- directed self-checking bench for pc_gen.
// Main instance: PC_WIDTH=32, RESET_PC=0, PC_STEP=4, BOOT_CYCLES=3.
// Wrap instance: PC_WIDTH=8, RESET_PC=0xF8, BOOT_CYCLES=1.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, halt, resume, redirect, trap, ready;
  logic [31:0] redirect_pc, trap_pc;
  logic        ena, valid, misalign;
  logic [31:0] pc, cnt;

  logic        ready8;
  logic        ena8, valid8, mis8;
  logic [7:0]  pc8, cnt8;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pc_gen #(
    .PC_WIDTH(32), .RESET_PC(32'h0), .PC_STEP(4), .BOOT_CYCLES(3), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena_o(ena), .stall_i(stall), .halt_i(halt),
    .resume_i(resume), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .trap_i(trap), .trap_pc_i(trap_pc), .fetch_valid_o(valid),
    .fetch_ready_i(ready), .pc_o(pc), .fetch_cnt_o(cnt), .misalign_o(misalign)
  );

  pc_gen #(
    .PC_WIDTH(8), .RESET_PC(8'hF8), .PC_STEP(4), .BOOT_CYCLES(1), .CNT_WIDTH(8)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .ena_o(ena8), .stall_i(1'b0), .halt_i(1'b0),
    .resume_i(1'b0), .redirect_i(1'b0), .redirect_pc_i(8'h00),
    .trap_i(1'b0), .trap_pc_i(8'h00), .fetch_valid_o(valid8),
    .fetch_ready_i(ready8), .pc_o(pc8), .fetch_cnt_o(cnt8), .misalign_o(mis8)
  );

  // One clock; acc says whether the main instance accepted a fetch on it.
  task automatic tick(input bit acc);
    @(posedge clk);
    #1;
    if (acc) exp_cnt++;
  endtask

  task automatic clear_inputs();
    stall = 0; halt = 0; resume = 0; redirect = 0; trap = 0;
    redirect_pc = '0; trap_pc = '0;
  endtask

  task automatic test_reset();
    rst_n = 0; clear_inputs(); ready = 1; ready8 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ena !== 1'b0)   begin errors++; $display("FAIL rst_ena: got %b want 0", ena); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid); end
    checks++; if (pc !== 32'h0)   begin errors++; $display("FAIL rst_pc: got %h want 0", pc); end
    checks++; if (cnt !== 32'h0)  begin errors++; $display("FAIL rst_cnt: got %0d want 0", cnt); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b want 0", misalign); end
    checks++; if (pc8 !== 8'hF8)  begin errors++; $display("FAIL rst_pc8: got %h want f8", pc8); end
    exp_cnt = 0;
    rst_n = 1;
  endtask

  task automatic test_boot();
    tick(0);
    checks++; if (ena !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL boot_e1: ena=%b valid=%b want 0/0", ena, valid); end
    tick(0);
    checks++; if (ena !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL boot_e2: ena=%b valid=%b want 0/0", ena, valid); end
    tick(0);
    checks++; if (ena !== 1'b1 || valid !== 1'b1) begin errors++; $display("FAIL boot_e3: ena=%b valid=%b want 1/1", ena, valid); end
    checks++; if (pc !== 32'h0 || cnt !== 32'd0) begin errors++; $display("FAIL boot_e3_pc: pc=%h cnt=%0d want 0/0", pc, cnt); end
  endtask

  task automatic test_step();
    tick(1);
    checks++; if (pc !== 32'h4 || cnt !== 32'd1) begin errors++; $display("FAIL step1: pc=%h cnt=%0d want 4/1", pc, cnt); end
    tick(1);
    checks++; if (pc !== 32'h8 || cnt !== 32'd2) begin errors++; $display("FAIL step2: pc=%h cnt=%0d want 8/2", pc, cnt); end
  endtask

  task automatic test_trap_priority();
    tick(1); tick(1);
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL pre_trap_pc: got %h want 10", pc); end
    trap = 1; trap_pc = 32'h100; redirect = 1; redirect_pc = 32'h200;
    tick(1);
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL trap_over_redirect: got %h want 100", pc); end
    clear_inputs();
    redirect = 1; redirect_pc = 32'h20;
    tick(1);
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL redirect: got %h want 20", pc); end
    clear_inputs();
    checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL cnt_after_trap: got %0d want %0d", cnt, exp_cnt); end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++; if (pc !== 32'h20 || cnt !== exp_cnt) begin errors++; $display("FAIL stall_%0d: pc=%h cnt=%0d want 20/%0d", i, pc, cnt, exp_cnt); end
    end
    stall = 0;
    tick(1);
    checks++; if (pc !== 32'h24) begin errors++; $display("FAIL stall_release: got %h want 24", pc); end
    ready = 0;
    tick(0);
    checks++; if (pc !== 32'h24 || cnt !== exp_cnt) begin errors++; $display("FAIL not_ready: pc=%h cnt=%0d want 24/%0d", pc, cnt, exp_cnt); end
    ready = 1;
  endtask

  task automatic test_halt();
    halt = 1;
    tick(1);
    halt = 0;
    checks++; if (valid !== 1'b0 || ena !== 1'b0 || pc !== 32'h24) begin errors++; $display("FAIL halt_enter: valid=%b ena=%b pc=%h want 0/0/24", valid, ena, pc); end
    redirect = 1; redirect_pc = 32'h300; stall = 1;
    tick(0);
    clear_inputs();
    checks++; if (valid !== 1'b0 || pc !== 32'h24 || cnt !== exp_cnt) begin errors++; $display("FAIL halt_ignore: valid=%b pc=%h cnt=%0d want 0/24/%0d", valid, pc, cnt, exp_cnt); end
    trap = 1; trap_pc = 32'h80; resume = 1;
    tick(0);
    clear_inputs();
    checks++; if (valid !== 1'b1 || pc !== 32'h80) begin errors++; $display("FAIL halt_trap_wake: valid=%b pc=%h want 1/80", valid, pc); end
    halt = 1;
    tick(1);
    halt = 0;
    checks++; if (valid !== 1'b0 || pc !== 32'h80) begin errors++; $display("FAIL halt_again: valid=%b pc=%h want 0/80", valid, pc); end
    resume = 1;
    tick(0);
    resume = 0;
    checks++; if (valid !== 1'b1 || pc !== 32'h80) begin errors++; $display("FAIL resume: valid=%b pc=%h want 1/80", valid, pc); end
    tick(1);
    checks++; if (pc !== 32'h84 || cnt !== exp_cnt) begin errors++; $display("FAIL post_resume: pc=%h cnt=%0d want 84/%0d", pc, cnt, exp_cnt); end
  endtask

  task automatic test_halt_redirect();
    halt = 1; redirect = 1; redirect_pc = 32'h40;
    tick(1);
    clear_inputs();
    checks++; if (valid !== 1'b0 || pc !== 32'h40) begin errors++; $display("FAIL halt_redirect: valid=%b pc=%h want 0/40", valid, pc); end
    resume = 1;
    tick(0);
    resume = 0;
    checks++; if (valid !== 1'b1 || pc !== 32'h40) begin errors++; $display("FAIL halt_redirect_resume: valid=%b pc=%h want 1/40", valid, pc); end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc1, exp_pc2;
    logic        exp_mis;
`ifdef PC_ALIGN_CHK_EN
    exp_pc1 = 32'h44;  exp_pc2 = 32'h48;  exp_mis = 1'b1;
`else
    exp_pc1 = 32'h202; exp_pc2 = 32'h206; exp_mis = 1'b0;
`endif
    redirect = 1; redirect_pc = 32'h202;
    tick(1);
    clear_inputs();
    checks++; if (pc !== exp_pc1 || misalign !== exp_mis) begin errors++; $display("FAIL misalign_redirect: pc=%h mis=%b want %h/%b", pc, misalign, exp_pc1, exp_mis); end
    tick(1);
    checks++; if (pc !== exp_pc2 || misalign !== 1'b0) begin errors++; $display("FAIL misalign_after: pc=%h mis=%b want %h/0", pc, misalign, exp_pc2); end
    checks++; if (cnt !== exp_cnt) begin errors++; $display("FAIL cnt_total: got %0d want %0d", cnt, exp_cnt); end
  endtask

  task automatic test_wrap();
    checks++; if (pc8 !== 8'hF8 || valid8 !== 1'b1) begin errors++; $display("FAIL wrap_hold: pc8=%h valid8=%b want f8/1", pc8, valid8); end
    ready8 = 1;
    tick(0);
    checks++; if (pc8 !== 8'hFC) begin errors++; $display("FAIL wrap_fc: got %h want fc", pc8); end
    tick(0);
    ready8 = 0;
    checks++; if (pc8 !== 8'h00 || cnt8 !== 8'd2) begin errors++; $display("FAIL wrap_00: pc8=%h cnt8=%0d want 00/2", pc8, cnt8); end
  endtask

  task automatic test_reset_mid();
    rst_n = 0;
    #1;
    checks++; if (ena !== 1'b0 || valid !== 1'b0 || pc !== 32'h0 || cnt !== 32'd0) begin errors++; $display("FAIL async_reset: ena=%b valid=%b pc=%h cnt=%0d want 0/0/0/0", ena, valid, pc, cnt); end
    @(posedge clk);
    #1;
    rst_n = 1; exp_cnt = 0;
    trap = 1; trap_pc = 32'h500; halt = 1; redirect = 1; redirect_pc = 32'h600;
    tick(0); tick(0);
    checks++; if (ena !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL boot_ignore: ena=%b pc=%h want 0/0", ena, pc); end
    tick(0);
    clear_inputs();
    checks++; if (ena !== 1'b1 || pc !== 32'h0 || cnt !== 32'd0) begin errors++; $display("FAIL reboot_run: ena=%b pc=%h cnt=%0d want 1/0/0", ena, pc, cnt); end
    tick(1);
    checks++; if (pc !== 32'h4 || cnt !== 32'd1) begin errors++; $display("FAIL reboot_step: pc=%h cnt=%0d want 4/1", pc, cnt); end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_step();
    test_trap_priority();
    test_stall();
    test_halt();
    test_halt_redirect();
    test_misalign();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator: successor to the single-register PC with a fixed reset vector and a one-cycle enable. It holds the current fetch PC and selects the next PC with priority trap > redirect > halt/stall > sequential step. It runs a boot/run/halt state machine that drives the system enable and a fetch valid/ready handshake, and counts accepted fetches. It sits at the front of the core, feeding the instruction-fetch stage.

## Interface
Parameters:
- PC_WIDTH, 32, PC and target width in bits
- RESET_PC, 0, PC value loaded at reset and held during BOOT
- PC_STEP, 4, sequential increment; power of two, ≥1
- BOOT_CYCLES, 1, clocks spent in BOOT after reset release; ≥1
- CNT_WIDTH, 32, width of fetch counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ena_o  out  1  system enable; 1 only in RUN
- stall_i  in  1  downstream stall; hold PC
- halt_i  in  1  request to enter HALT
- resume_i  in  1  leave HALT
- redirect_i  in  1  branch/jump taken
- redirect_pc_i  in  PC_WIDTH  branch/jump target
- trap_i  in  1  trap/interrupt entry
- trap_pc_i  in  PC_WIDTH  trap vector
- fetch_valid_o  out  1  pc_o is a valid fetch request
- fetch_ready_i  in  1  fetch stage accepts pc_o
- pc_o  out  PC_WIDTH  current PC
- fetch_cnt_o  out  CNT_WIDTH  number of accepted fetches (valid & ready)
- misalign_o  out  1  one-cycle pulse on a rejected misaligned redirect (see Configuration)

## Operation
- States: BOOT, RUN, HALT. Reset forces BOOT with boot counter 0.
- Reset values: ena_o=0, fetch_valid_o=0, pc_o=RESET_PC, fetch_cnt_o=0, misalign_o=0.
- BOOT:
  - ena_o=0, fetch_valid_o=0, pc_o=RESET_PC.
  - All requests (trap, redirect, halt, stall) are ignored.
  - The boot counter increments each clock. On the clock where the counter equals BOOT_CYCLES-1, go to RUN.
- RUN:
  - ena_o=1, fetch_valid_o=1.
  - Next PC, by priority:
    1. trap_i → trap_pc_i
    2. redirect_i → redirect_pc_i
    3. halt_i, stall_i, or !fetch_ready_i → hold
    4. otherwise → pc_o+PC_STEP
  - A fetch is accepted when fetch_valid_o & fetch_ready_i; fetch_cnt_o increments by 1 and wraps at 2^CNT_WIDTH.
  - halt_i with no trap → next state HALT. A redirect in the same cycle still loads its target.
- HALT:
  - ena_o=0, fetch_valid_o=0, PC held, no counting.
  - trap_i → load trap_pc_i, go to RUN (wake-up).
  - resume_i → go to RUN, PC unchanged. If trap_i and resume_i are both asserted, trap_i wins.
  - redirect_i, stall_i and halt_i are ignored.
- Arithmetic: pc_o+PC_STEP is truncated to PC_WIDTH (wraps 2^PC_WIDTH-PC_STEP → 0).
- Reset mid-operation: any state immediately returns to BOOT with all reset values. Any pending request is discarded.

## Timing
- All outputs are registered and change only on the clk rising edge, except during asynchronous reset.
- Redirect/trap latency: asserted in cycle N → pc_o = target in cycle N+1.
- ena_o and fetch_valid_o rise exactly BOOT_CYCLES clocks after the first rising edge with rst_n=1. With BOOT_CYCLES=1, they are 1 after the first edge.
- halt_i in cycle N → fetch_valid_o=0 from N+1. resume_i in HALT cycle M → fetch_valid_o=1 from M+1.
- fetch_cnt_o reflects an acceptance in cycle N from cycle N+1.
- misalign_o is high for exactly the cycle after the rejected redirect.

## Configuration
- PC_ALIGN_CHK_EN defined:
  - A redirect whose redirect_pc_i low log2(PC_STEP) bits are non-zero is rejected.
  - The PC behaves as if redirect_i=0 (the hold/step rules apply) and misalign_o pulses.
  - trap_pc_i is never checked.
- Not defined: redirects are taken as-is regardless of alignment; misalign_o is tied 0.

## Test plan
- Reset release, BOOT_CYCLES=3, fetch_ready_i=1 → ena_o/fetch_valid_o=0 for 3 edges, then pc_o 0x0 → 0x4 → 0x8 and fetch_cnt_o 0 → 1 → 2.
- At pc_o=0x10, assert trap_i (trap_pc_i=0x100) and redirect_i (redirect_pc_i=0x200) together → next pc_o=0x100.
- At pc_o=0x20, assert stall_i for 3 cycles → pc_o stays 0x20 and fetch_cnt_o still counts accepted cycles. Drop stall_i → 0x24.
- Assert halt_i, then trap_i in HALT with trap_pc_i=0x80 → fetch_valid_o=0 during HALT, then RUN with pc_o=0x80. Repeat with resume_i only → PC unchanged.
- PC_WIDTH=8, pc_o=0xFC, step → pc_o=0x00.
- With PC_ALIGN_CHK_EN, redirect to 0x202 at pc_o=0x40 → pc_o=0x44 and misalign_o=1 for one cycle. Without the macro → pc_o=0x202.
